octurdle_engine: RTL and testbench
==================================

# octurdle_engine

Parametrised Octurdle game engine: holds a pseudo-random secret code of `N_SLOTS` symbols, scores each entered guess per slot, counts turns and declares win or loss. It sits between the switch/guess input logic and the seven-segment/LED display driver. It replaces the fixed 4×3-bit comparator with the following additions:

- an on-chip LFSR for the secret,
- a turn limit and game state machine,
- a registered scoring stage,
- optional duplicate-aware scoring.

## Interface
Parameters:
- `N_SLOTS`, 4: symbols per code.
- `SYM_W`, 3: bits per symbol. `N_SLOTS*SYM_W` must be ≤ 16.
- `MAX_TURNS`, 6: guesses allowed per game. Must be ≥ 1.
- `SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clk`  in  1  system clock. The block uses one clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `guess`  in  `N_SLOTS*SYM_W`  current guess; slot i = `guess[i*SYM_W +: SYM_W]`, slot 0 in the LSBs.
- `enter`  in  1  single-cycle guess strobe, already debounced and pulsed upstream.
- `new_game`  in  1  single-cycle strobe: start a game.
- `fb`  out  `2*N_SLOTS`  per-slot feedback code, slot i = `fb[2i+:2]`.
- `fb_valid`  out  1  one-cycle pulse when `fb` updates.
- `turn`  out  `$clog2(MAX_TURNS+1)`  guesses scored in the current game.
- `win`  out  1  level; high while in WON.
- `lose`  out  1  level; high while in LOST.
- `playing`  out  1  high in PLAY or SCORE.
- `secret`  out  `N_SLOTS*SYM_W`  current secret, used for the end-of-game reveal.

## Operation
- Feedback codes:
  - 2'b00 ABSENT
  - 2'b01 PRESENT (symbol is in the secret, wrong slot)
  - 2'b10 EXACT
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including in IDLE. Reset loads `SEED`.
- States: IDLE, PLAY, SCORE, WON, LOST. Reset enters IDLE.
- `new_game` in any state:
  - `secret` ← `lfsr[N_SLOTS*SYM_W-1:0]`,
  - `turn` ← 0, `fb` ← 0,
  - next state PLAY.
- PLAY, `enter`=1: latch `guess` into the internal guess register; next state SCORE. `enter` outside PLAY is ignored.
- SCORE:
  - register `fb` and pulse `fb_valid`; `turn` increments by 1;
  - all slots EXACT → WON;
  - else if the incremented `turn` == `MAX_TURNS` → LOST;
  - else → PLAY.
- WON and LOST hold until `new_game`. `fb`, `turn` and `secret` stay frozen.
- Base scoring, per slot i:
  - EXACT if `guess[i]` == `secret[i]`;
  - else PRESENT if `guess[i]` equals any `secret[j]`, j≠i;
  - else ABSENT.
- A win requires all slots EXACT; a win on turn `MAX_TURNS` is a win, not a loss.

## Timing
- Reset values: `fb`=0, `fb_valid`=0, `turn`=0, `win`=0, `lose`=0, `playing`=0, `secret`=0, state IDLE, LFSR=`SEED`.
- Latency: `enter` sampled at edge k → `fb`/`fb_valid`/`turn` update at edge k+1. `win`/`lose` assert at edge k+2 (state register).
- `new_game` and `enter` in the same cycle: `new_game` wins, `enter` is dropped.
- `new_game` while in SCORE: scoring is aborted, there is no `fb_valid` pulse, and the state goes to PLAY.
- `enter` held high across cycles: only the first cycle in PLAY is taken; further cycles land in SCORE and are ignored.
- An asynchronous `reset` mid-game returns all outputs to their reset values immediately.

## Configuration
- `OCTURDLE_DUP_AWARE_EN` defined:
  - PRESENT credit is duplicate-aware. EXACT slots are resolved first.
  - Then non-exact guess slots are scanned from slot 0 upward. Each is credited PRESENT only against a not-yet-used, non-exact secret slot holding the same symbol; that secret slot is then marked used.
  - This is still single-cycle in SCORE.
- Undefined: base scoring, where repeated guess symbols can each be PRESENT against one secret symbol.

## Structure
- `octurdle_pkg`:
  - `fb_code_e` enum (FB_ABSENT, FB_PRESENT, FB_EXACT),
  - `game_state_e` enum,
  - `LFSR_TAPS` constant (16'hB400),
  - `LFSR_W`=16.
- Sub-module `octurdle_lfsr`: the free-running LFSR with asynchronous reset to `SEED`. Scorer and FSM are in the top module.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `playing`=0. `enter` pulses produce no `fb_valid`.
- `new_game`; force `secret`=(3,2,1,0) via `SEED`; guess (3,2,1,0) → `fb_valid` 1 cycle after `enter`; `fb`=all EXACT, `turn`=1, `win`=1 the next cycle, `playing`=0.
- Secret (0,1,2,3), guess slot0..3 = (3,5,2,0) → `fb` slot0 PRESENT, slot1 ABSENT, slot2 EXACT, slot3 PRESENT.
- Six wrong guesses with `MAX_TURNS`=6 → `turn`=6, `lose`=1. A 7th `enter` is ignored; `new_game` clears `turn` and `lose`.
- Secret slots (1,1,2,3), guess (1,2,1,1):
  - with `OCTURDLE_DUP_AWARE_EN` → EXACT, PRESENT, PRESENT, ABSENT;
  - without it → EXACT, PRESENT, PRESENT, PRESENT.
- `new_game` and `enter` in the same cycle, then `new_game` during SCORE → no `fb_valid` in either case; state PLAY, `turn`=0.

Source files
------------

// File: rtl/octurdle_pkg.sv
// Shared types and constants for the Octurdle game engine.
package octurdle_pkg;

    localparam int LFSR_W = 16;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask on the shift register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        FB_ABSENT  = 2'b00,
        FB_PRESENT = 2'b01,
        FB_EXACT   = 2'b10
    } fb_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_SCORE,
        ST_WON,
        ST_LOST
    } game_state_e;

    // One left shift of the Fibonacci LFSR; feedback is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/octurdle_engine_lfsr.sv
// Free-running 16-bit LFSR used to draw the secret code.
// Advances on every clock, whatever the game state is.
module octurdle_lfsr
    import octurdle_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] rnd
);

    logic [LFSR_W-1:0] lfsr_q;

    // Shift every cycle; reset reloads the seed (must be non-zero).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/octurdle_engine.sv
// Octurdle game engine: secret draw, registered per-slot scoring, turn
// counting and win/loss state machine.
// Optional feature: define OCTURDLE_DUP_AWARE_EN for duplicate-aware PRESENT
// credit; otherwise each guess slot is scored independently.
module octurdle_engine
    import octurdle_pkg::*;
#(
    parameter int                N_SLOTS   = 4,
    parameter int                SYM_W     = 3,
    parameter int                MAX_TURNS = 6,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_SLOTS*SYM_W-1:0]         guess,
    input  logic                             enter,
    input  logic                             new_game,
    output logic [2*N_SLOTS-1:0]             fb,
    output logic                             fb_valid,
    output logic [$clog2(MAX_TURNS+1)-1:0]   turn,
    output logic                             win,
    output logic                             lose,
    output logic                             playing,
    output logic [N_SLOTS*SYM_W-1:0]         secret
);

    localparam int CODE_W = N_SLOTS * SYM_W;
    localparam int TURN_W = $clog2(MAX_TURNS + 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(MAX_TURNS);

    game_state_e         state;
    logic [CODE_W-1:0]   guess_q;
    logic [CODE_W-1:0]   lfsr_rnd;
    logic [2*N_SLOTS-1:0] fb_calc;
    logic [N_SLOTS-1:0]  exact;
    logic                all_exact;
    logic [TURN_W-1:0]   turn_inc;

    octurdle_lfsr #(
        .SEED  (SEED),
        .OUT_W (CODE_W)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .rnd   (lfsr_rnd)
    );

    // Per-slot scoring of the latched guess against the current secret.
    always_comb begin
`ifdef OCTURDLE_DUP_AWARE_EN
        logic [N_SLOTS-1:0] used;
`endif
        logic found;
        fb_calc = '0;
        exact   = '0;
        found   = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            exact[i] = (guess_q[i*SYM_W +: SYM_W] == secret[i*SYM_W +: SYM_W]);
        end
`ifdef OCTURDLE_DUP_AWARE_EN
        // Exact secret slots are already consumed; each remaining secret
        // slot can back at most one PRESENT, claimed lowest guess slot first.
        used = exact;
        for (int i = 0; i < N_SLOTS; i++) begin
            found = 1'b0;
            if (!exact[i]) begin
                for (int j = 0; j < N_SLOTS; j++) begin
                    if (!found && !used[j] &&
                        guess_q[i*SYM_W +: SYM_W] == secret[j*SYM_W +: SYM_W]) begin
                        found   = 1'b1;
                        used[j] = 1'b1;
                    end
                end
            end
            fb_calc[2*i +: 2] = exact[i] ? FB_EXACT : (found ? FB_PRESENT : FB_ABSENT);
        end
`else
        for (int i = 0; i < N_SLOTS; i++) begin
            found = 1'b0;
            for (int j = 0; j < N_SLOTS; j++) begin
                if (j != i && guess_q[i*SYM_W +: SYM_W] == secret[j*SYM_W +: SYM_W]) begin
                    found = 1'b1;
                end
            end
            fb_calc[2*i +: 2] = exact[i] ? FB_EXACT : (found ? FB_PRESENT : FB_ABSENT);
        end
`endif
    end

    assign all_exact = &exact;
    assign turn_inc  = turn + 1'b1;

    // Game FSM; win/lose/playing are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            guess_q  <= '0;
            secret   <= '0;
            fb       <= '0;
            fb_valid <= 1'b0;
            turn     <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
            playing  <= 1'b0;
        end else begin
            fb_valid <= 1'b0;
            win      <= (state == ST_WON);
            lose     <= (state == ST_LOST);
            playing  <= (state == ST_PLAY) || (state == ST_SCORE);
            if (new_game) begin
                // Overrides everything, including a pending score or a same-cycle enter.
                secret <= lfsr_rnd;
                turn   <= '0;
                fb     <= '0;
                state  <= ST_PLAY;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (enter) begin
                            guess_q <= guess;
                            state   <= ST_SCORE;
                        end
                    end
                    ST_SCORE: begin
                        fb       <= fb_calc;
                        fb_valid <= 1'b1;
                        turn     <= turn_inc;
                        if (all_exact) begin
                            state <= ST_WON;
                        end else if (turn_inc == TURN_LAST) begin
                            state <= ST_LOST;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_octurdle_engine.sv
// Directed testbench for octurdle_engine (4 slots x 3 bits, 6 turns).
module tb_octurdle_engine;

    localparam logic [15:0] TB_SEED = 16'h0053;   // low 12 bits = slots (3,2,1,0)

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] guess = '0;
    logic        enter = 1'b0;
    logic        new_game = 1'b0;
    logic [7:0]  fb;
    logic        fb_valid;
    logic [2:0]  turn;
    logic        win;
    logic        lose;
    logic        playing;
    logic [11:0] secret;

    int checks = 0;
    int errors = 0;

    octurdle_engine #(
        .N_SLOTS   (4),
        .SYM_W     (3),
        .MAX_TURNS (6),
        .SEED      (TB_SEED)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .guess    (guess),
        .enter    (enter),
        .new_game (new_game),
        .fb       (fb),
        .fb_valid (fb_valid),
        .turn     (turn),
        .win      (win),
        .lose     (lose),
        .playing  (playing),
        .secret   (secret)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] model_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [15:0] model_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) model_lfsr <= TB_SEED;
        else       model_lfsr <= model_next(model_lfsr);
    end

    function automatic logic [11:0] pack(input logic [2:0] s0, input logic [2:0] s1,
                                         input logic [2:0] s2, input logic [2:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Drive one guess from a negedge; returns negedges until fb_valid (-1 if none in 4).
    task automatic do_guess(input logic [11:0] g, output int lat);
        guess = g;
        enter = 1'b1;
        lat   = -1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            enter = 1'b0;
            if (fb_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    // Wait until the LFSR low bits equal target, then pulse new_game so it is drawn.
    task automatic start_game(input logic [11:0] target);
        logic [15:0] s;
        int k;
        s = model_lfsr;
        k = 0;
        while (k < 65536 && s[11:0] != target) begin
            s = model_next(s);
            k++;
        end
        checks++;
        if (k >= 65536) begin
            errors++;
            $display("FAIL start_game search: got no match want %h", target);
        end else begin
            repeat (k) @(negedge clk);
            new_game = 1'b1;
            @(negedge clk);
            new_game = 1'b0;
            checks++;
            if (secret !== target) begin
                errors++;
                $display("FAIL start_game secret: got %h want %h", secret, target);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({fb, fb_valid, turn, win, lose, playing, secret} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h want 0", {fb, fb_valid, turn, win, lose, playing, secret});
        end
        @(negedge clk);
        reset = 1'b0;
        guess = 12'h053;
        for (int c = 0; c < 5; c++) begin
            enter = (c % 2 == 0);
            @(negedge clk);
            checks++;
            if (fb_valid !== 1'b0 || playing !== 1'b0 || turn !== 3'd0) begin
                errors++;
                $display("FAIL idle cycle %0d: got fb_valid=%b playing=%b turn=%0d want 0 0 0",
                         c, fb_valid, playing, turn);
            end
        end
        enter = 1'b0;
        checks++;
        if ({fb, win, lose, secret} !== '0) begin
            errors++;
            $display("FAIL idle outputs: got %h want 0", {fb, win, lose, secret});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_win();
        reset    = 1'b0;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        checks++;
        if (secret !== pack(3, 2, 1, 0)) begin
            errors++;
            $display("FAIL win secret from seed: got %h want %h", secret, pack(3, 2, 1, 0));
        end
        @(negedge clk);
        checks++;
        if (playing !== 1'b1) begin
            errors++;
            $display("FAIL win playing: got %b want 1", playing);
        end
        guess = pack(3, 2, 1, 0);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        checks++;
        if (fb_valid !== 1'b0) begin
            errors++;
            $display("FAIL win early fb_valid: got %b want 0", fb_valid);
        end
        @(negedge clk);
        checks++;
        if (fb_valid !== 1'b1 || fb !== 8'hAA || turn !== 3'd1 || win !== 1'b0) begin
            errors++;
            $display("FAIL win score: got v=%b fb=%h turn=%0d win=%b want 1 aa 1 0", fb_valid, fb, turn, win);
        end
        @(negedge clk);
        checks++;
        if (win !== 1'b1 || playing !== 1'b0 || lose !== 1'b0 || fb_valid !== 1'b0) begin
            errors++;
            $display("FAIL win level: got win=%b playing=%b lose=%b v=%b want 1 0 0 0", win, playing, lose, fb_valid);
        end
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fb_valid !== 1'b0 || turn !== 3'd1 || win !== 1'b1 || fb !== 8'hAA) begin
            errors++;
            $display("FAIL win hold: got v=%b turn=%0d win=%b fb=%h want 0 1 1 aa", fb_valid, turn, win, fb);
        end
    endtask

    task automatic test_present();
        int lat;
        start_game(pack(0, 1, 2, 3));
        do_guess(pack(3, 5, 2, 0), lat);
        checks++;
        if (lat !== 2 || fb !== {2'b01, 2'b10, 2'b00, 2'b01} || turn !== 3'd1) begin
            errors++;
            $display("FAIL present score: got lat=%0d fb=%h turn=%0d want 2 61 1", lat, fb, turn);
        end
    endtask

    task automatic test_lose();
        int lat;
        logic [11:0] sec;
        sec      = model_lfsr[11:0];
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        checks++;
        if (secret !== sec) begin
            errors++;
            $display("FAIL lose secret draw: got %h want %h", secret, sec);
        end
        for (int t = 1; t <= 6; t++) begin
            do_guess(sec ^ 12'h001, lat);
            checks++;
            if (lat !== 2 || turn !== 3'(t) || fb[7:2] !== 6'b101010) begin
                errors++;
                $display("FAIL lose turn %0d: got lat=%0d turn=%0d fb=%h want 2 %0d slots1-3 exact",
                         t, lat, turn, fb, t);
            end
        end
        @(negedge clk);
        checks++;
        if (lose !== 1'b1 || win !== 1'b0 || playing !== 1'b0) begin
            errors++;
            $display("FAIL lose level: got lose=%b win=%b playing=%b want 1 0 0", lose, win, playing);
        end
        do_guess(sec, lat);
        checks++;
        if (lat !== -1 || turn !== 3'd6 || lose !== 1'b1) begin
            errors++;
            $display("FAIL lose extra enter: got lat=%0d turn=%0d lose=%b want -1 6 1", lat, turn, lose);
        end
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        @(negedge clk);
        checks++;
        if (turn !== 3'd0 || lose !== 1'b0 || playing !== 1'b1 || fb !== 8'h00) begin
            errors++;
            $display("FAIL lose restart: got turn=%0d lose=%b playing=%b fb=%h want 0 0 1 00", turn, lose, playing, fb);
        end
    endtask

    task automatic test_dup();
        int lat;
        logic [7:0] exp_fb;
`ifdef OCTURDLE_DUP_AWARE_EN
        exp_fb = {2'b00, 2'b01, 2'b01, 2'b10};
`else
        exp_fb = {2'b01, 2'b01, 2'b01, 2'b10};
`endif
        start_game(pack(1, 1, 2, 3));
        do_guess(pack(1, 2, 1, 1), lat);
        checks++;
        if (lat !== 2 || fb !== exp_fb || turn !== 3'd1) begin
            errors++;
            $display("FAIL dup score: got lat=%0d fb=%h turn=%0d want 2 %h 1", lat, fb, turn, exp_fb);
        end
    endtask

    task automatic test_collision();
        int lat;
        int seen;
        guess    = 12'h123;
        new_game = 1'b1;
        enter    = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        enter    = 1'b0;
        seen     = 0;
        repeat (3) begin
            @(negedge clk);
            if (fb_valid) seen++;
        end
        checks++;
        if (seen !== 0 || turn !== 3'd0) begin
            errors++;
            $display("FAIL same-cycle new_game/enter: got pulses=%0d turn=%0d want 0 0", seen, turn);
        end
        enter = 1'b1;
        @(negedge clk);
        enter    = 1'b0;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        seen     = fb_valid ? 1 : 0;
        @(negedge clk);
        if (fb_valid) seen++;
        checks++;
        if (seen !== 0 || turn !== 3'd0 || playing !== 1'b1) begin
            errors++;
            $display("FAIL abort in SCORE: got pulses=%0d turn=%0d playing=%b want 0 0 1", seen, turn, playing);
        end
        do_guess(12'h000, lat);
        checks++;
        if (lat !== 2 || turn !== 3'd1) begin
            errors++;
            $display("FAIL play after abort: got lat=%0d turn=%0d want 2 1", lat, turn);
        end
        guess = 12'h000;
        enter = 1'b1;
        seen  = 0;
        repeat (2) begin
            @(negedge clk);
            if (fb_valid) seen++;
        end
        enter = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (fb_valid) seen++;
        end
        checks++;
        if (seen !== 1 || turn !== 3'd2) begin
            errors++;
            $display("FAIL held enter: got pulses=%0d turn=%0d want 1 2", seen, turn);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({fb, fb_valid, turn, win, lose, playing, secret} !== '0) begin
            errors++;
            $display("FAIL async reset: got %h want 0", {fb, fb_valid, turn, win, lose, playing, secret});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_win();
        test_present();
        test_lose();
        test_dup();
        test_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
